// File: rtl/serv_mem_ctrl_pkg.sv
// Shared types and size helpers for the serial load/store unit.
// Access sizes, FSM states and the lane-select/split result bundle.
package serv_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT1 = 2'd1,
    ST_BEAT2 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef struct packed {
    logic       split;
    logic [3:0] sel1;
    logic [3:0] sel2;
  } align_t;

  function automatic logic [3:0] size_mask(size_e sz);
    case (sz)
      SZ_WORD: return MASK_WORD;
      SZ_HALF: return MASK_HALF;
      default: return MASK_BYTE;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(size_e sz);
    case (sz)
      SZ_WORD: return 3'd4;
      SZ_HALF: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  // Width of the access in bits; serial positions at or beyond this are sign fill.
  function automatic logic [5:0] size_bits(size_e sz);
    case (sz)
      SZ_WORD: return 6'd32;
      SZ_HALF: return 6'd16;
      default: return 6'd8;
    endcase
  endfunction

  function automatic bit w_legal(int w);
    return (w == 1) || (w == 4);
  endfunction

endpackage

// File: rtl/serv_mem_ctrl_if.sv
// Wishbone classic data bus between the load/store unit and memory.
interface serv_mem_ctrl_if;
  logic [29:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/serv_mem_ctrl_align.sv
// Byte-lane steering: lane selects, split detection, store rotate and load merge.
// Purely combinational; lo is the byte offset of the access within its word.
module serv_mem_ctrl_align
  import serv_mem_ctrl_pkg::*;
(
  input  logic [1:0]  lo,
  input  size_e       sz,
  input  logic [31:0] st_dat,
  input  logic [31:0] rdt,
  input  logic [31:0] cur_dat,
  output align_t      al,
  output logic [31:0] wb_dat,
  output logic [31:0] ld_beat1,
  output logic [31:0] ld_beat2
);

  logic [7:0]  sel_w;
  logic [4:0]  sh;
  logic [5:0]  sh_inv;
  logic [31:0] rd_rot;

  assign sh     = {lo, 3'b000};
  assign sh_inv = 6'd32 - {1'b0, sh};

  // Mask spans two words when it runs past lane 3; upper nibble is beat 2.
  assign sel_w    = {4'b0000, size_mask(sz)} << lo;
  assign al.split = ({1'b0, lo} + size_bytes(sz)) > 3'd4;
  assign al.sel1  = sel_w[3:0];
  assign al.sel2  = sel_w[7:4];

  assign wb_dat   = (st_dat << sh) | (st_dat >> sh_inv);
  assign rd_rot   = (rdt >> sh) | (rdt << sh_inv);
  assign ld_beat1 = rdt >> sh;

  // Second beat fills only the top lo bytes; the lower bytes came from beat 1.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign ld_beat2[8*k +: 8] = (({1'b0, lo} + 3'(k)) >= 3'd4) ? rd_rot[8*k +: 8]
                                                               : cur_dat[8*k +: 8];
  end

endmodule

// File: rtl/serv_mem_ctrl.sv
// Bit/nibble-serial load/store unit for SERV on a Wishbone classic bus.
// Holds the access FSM, the shared data shift register and the serial position counter.
module serv_mem_ctrl
  import serv_mem_ctrl_pkg::*;
#(
  parameter int W             = 1,
  parameter bit WITH_MISALIGN = 1'b1,
  parameter bit WITH_CSR      = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_init,
  input  logic          i_req,
  input  logic          i_we,
  input  logic          i_signed,
  input  logic          i_word,
  input  logic          i_half,
  input  logic [31:0]   i_adr,
  input  logic [W-1:0]  i_op_b,
  output logic [W-1:0]  o_rd,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_misalign,
  serv_mem_ctrl_if.master wb
);

  if (!w_legal(W)) begin : g_w_chk
    $error("serv_mem_ctrl: W must be 1 or 4");
  end

  state_e      state, state_nxt;
  logic [31:0] dat;
  logic [4:0]  cnt;
  logic [29:0] adr_r;
  logic [1:0]  lo_r;
  size_e       sz_r;
  logic        we_r;
  logic        signed_r;
  logic        sign_r;

  size_e       sz_in;
  logic        accept;
  logic        split_en;
  logic        shift_out;
  logic        sign_src;
  align_t      al;
  logic [31:0] wb_rot, ld_beat1, ld_beat2;

  logic        cyc_c, we_c, done_c;
  logic [29:0] adr_c;
  logic [3:0]  sel_c;
  logic [31:0] dat_c;

  assign sz_in      = i_word ? SZ_WORD : (i_half ? SZ_HALF : SZ_BYTE);
  assign o_misalign = WITH_CSR && !WITH_MISALIGN &&
                      ((i_word && (i_adr[1:0] != 2'b00)) || (i_half && i_adr[0]));
  assign accept     = (state == ST_IDLE) && i_req && !o_misalign;
  assign split_en   = WITH_MISALIGN && al.split;
  assign shift_out  = i_en && !i_init;

  serv_mem_ctrl_align u_align (
    .lo       (lo_r),
    .sz       (sz_r),
    .st_dat   (dat),
    .rdt      (wb.rdt),
    .cur_dat  (dat),
    .al       (al),
    .wb_dat   (wb_rot),
    .ld_beat1 (ld_beat1),
    .ld_beat2 (ld_beat2)
  );

  always_comb begin
    state_nxt = state;
    cyc_c     = 1'b0;
    we_c      = 1'b0;
    done_c    = 1'b0;
    adr_c     = '0;
    sel_c     = '0;
    dat_c     = '0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_BEAT1;
      ST_BEAT1: begin
        cyc_c = 1'b1;
        we_c  = we_r;
        adr_c = adr_r;
        sel_c = al.sel1;
        dat_c = wb_rot;
        if (wb.ack) state_nxt = split_en ? ST_BEAT2 : ST_DONE;
      end
      ST_BEAT2: begin
        cyc_c = 1'b1;
        we_c  = we_r;
        adr_c = adr_r + 30'd1;
        sel_c = al.sel2;
        dat_c = wb_rot;
        if (wb.ack) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign wb.cyc = cyc_c;
  assign wb.we  = we_c;
  assign wb.adr = adr_c;
  assign wb.sel = sel_c;
  assign wb.dat = dat_c;
  assign o_done = done_c;
  assign o_busy = (state != ST_IDLE);

  always_comb begin
    case (sz_r)
      SZ_WORD: sign_src = dat[31];
      SZ_HALF: sign_src = dat[15];
      default: sign_src = dat[7];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      dat      <= '0;
      cnt      <= '0;
      adr_r    <= '0;
      lo_r     <= '0;
      sz_r     <= SZ_BYTE;
      we_r     <= 1'b0;
      signed_r <= 1'b0;
      sign_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        adr_r    <= i_adr[31:2];
        lo_r     <= i_adr[1:0];
        sz_r     <= sz_in;
        we_r     <= i_we;
        signed_r <= i_signed;
      end
      // Bus capture wins over serial shifting; the core never shifts mid-access.
      if (state == ST_BEAT1 && wb.ack && !we_r)
        dat <= ld_beat1;
      else if (state == ST_BEAT2 && wb.ack && !we_r)
        dat <= ld_beat2;
      else if (i_en)
        dat <= {(i_init ? i_op_b : {W{1'b0}}), dat[31:W]};
      if (done_c)
        cnt <= '0;
      else if (i_en)
        cnt <= cnt + 5'(W);
      // dat shifts during read-out, so the sign bit is frozen once the load completes.
      if (state == ST_DONE)
        sign_r <= signed_r & sign_src;
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_rd
    logic [5:0] pos;
    assign pos     = {1'b0, cnt} + 6'(i);
    assign o_rd[i] = shift_out & ((pos >= size_bits(sz_r)) ? sign_r : dat[i]);
  end

endmodule
